// File: rtl/y86_seq_pkg.sv
// Shared definitions for the sequential Y86-64 stage sequencer: status codes,
// instruction codes, FSM state encoding and stage bit positions.
package y86_seq_pkg;

  // Processor status codes.
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Y86-64 instruction codes.
  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RRMOVQ = 4'd2;
  localparam logic [3:0] I_IRMOVQ = 4'd3;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  // Bit positions inside stage_start / stage_done.
  localparam int STG_FETCH  = 0;
  localparam int STG_DECODE = 1;
  localparam int STG_EXEC   = 2;
  localparam int STG_MEM    = 3;
  localparam int STG_WB     = 4;
  localparam int NUM_STAGES = 5;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_PCUPD  = 4'd6,
    S_HALTED = 4'd7,
    S_FAULT  = 4'd8
  } seq_state_t;

  // Stage bit owned by a state; zero for states that are not stage states.
  function automatic logic [NUM_STAGES-1:0] stage_onehot(seq_state_t s);
    logic [NUM_STAGES-1:0] v;
    v = '0;
    case (s)
      S_FETCH:  v[STG_FETCH]  = 1'b1;
      S_DECODE: v[STG_DECODE] = 1'b1;
      S_EXEC:   v[STG_EXEC]   = 1'b1;
      S_MEM:    v[STG_MEM]    = 1'b1;
      S_WB:     v[STG_WB]     = 1'b1;
      default:  v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/y86_stage_wdog.sv
// Stage watchdog: loadable down-counter. o_expired is high while the count is
// zero; the count reloads to TIMEOUT-1 on i_load and otherwise stops at zero.
module y86_stage_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  // Reload on stage entry, otherwise count down to zero and hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(TIMEOUT - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/y86_seq_sequencer.sv
// Stage sequencer for the sequential Y86-64 core. Walks one instruction through
// fetch, decode, execute, memory, writeback and PC update, and sets stat.
// Optional stage watchdog: define Y86_SEQ_WDOG_EN to build it.
//
// Stage handshake: the sequencer raises stage_start[k] for exactly the entry
// cycle of stage k; the stage block answers by holding stage_done[k] high in
// any cycle from that entry cycle onward, and the sequencer leaves the stage
// on the first edge where it samples its own done bit high. Done bits of other
// stages are ignored. All outputs are registered.
module y86_seq_sequencer
  import y86_seq_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic [4:0]       stage_start,
  input  logic [4:0]       stage_done,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  output logic             pc_we,
  output logic             busy,
  output logic [2:0]       stat,
  output logic [CNT_W-1:0] instr_count,
  output logic             wdog_trip,
  output logic [3:0]       dbg_state
);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [4:0]       r_stage_start;
  logic             r_pc_we;
  logic             r_busy;
  logic [2:0]       r_stat;
  logic [2:0]       w_stat_next;
  logic [CNT_W-1:0] r_count;

  logic [4:0]       w_cur_bit;
  logic [4:0]       w_next_bit;
  logic             w_in_stage;
  logic             w_cur_done;
  logic             w_timeout;
  logic             w_timeout_fault;
  logic             w_entry;

  assign w_cur_bit       = stage_onehot(r_state);
  assign w_next_bit      = stage_onehot(w_next);
  assign w_in_stage      = |w_cur_bit;
  assign w_cur_done      = |(stage_done & w_cur_bit);
  // A done seen in the expiry cycle beats the timeout.
  assign w_timeout_fault = w_in_stage & ~w_cur_done & w_timeout;
  assign w_entry         = (|w_next_bit) && (w_next != r_state);

`ifdef Y86_SEQ_WDOG_EN
  logic r_wdog_trip;

  y86_stage_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_entry),
    .o_expired (w_timeout)
  );

  // Sticky record that a stage timed out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog_trip <= 1'b0;
    end else if (w_timeout_fault) begin
      r_wdog_trip <= 1'b1;
    end
  end

  assign wdog_trip = r_wdog_trip;
`else
  // Without the watchdog a stage waits for done forever.
  assign w_timeout = 1'b0;
  assign wdog_trip = 1'b0;
`endif

  // Next-state and next-status decision.
  always_comb begin
    w_next      = r_state;
    w_stat_next = r_stat;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (w_cur_done) begin
          if (imem_error) begin
            w_next      = S_FAULT;
            w_stat_next = STAT_ADR;
          end else if (!instr_valid) begin
            w_next      = S_FAULT;
            w_stat_next = STAT_INS;
          end else if (icode == I_HALT) begin
            w_next      = S_HALTED;
            w_stat_next = STAT_HLT;
          end else begin
            w_next = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (w_cur_done) w_next = S_EXEC;
      end
      S_EXEC: begin
        if (w_cur_done) w_next = S_MEM;
      end
      S_MEM: begin
        if (w_cur_done) begin
          if (dmem_error) begin
            w_next      = S_FAULT;
            w_stat_next = STAT_ADR;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        if (w_cur_done) w_next = S_PCUPD;
      end
      S_PCUPD: begin
        w_next = run ? S_FETCH : S_IDLE;
      end
      S_HALTED, S_FAULT: begin
        w_next = r_state;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_timeout_fault) begin
      w_next      = S_FAULT;
      w_stat_next = STAT_ADR;
    end
  end

  // State register and registered outputs, derived from the next state so
  // start pulses and pc_we line up with the cycle the state is occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_stage_start <= '0;
      r_pc_we       <= 1'b0;
      r_busy        <= 1'b0;
      r_stat        <= STAT_AOK;
      r_count       <= '0;
    end else begin
      r_state       <= w_next;
      r_stage_start <= w_entry ? w_next_bit : '0;
      r_pc_we       <= (w_next == S_PCUPD);
      r_busy        <= (|w_next_bit) || (w_next == S_PCUPD);
      r_stat        <= w_stat_next;
      if ((r_state == S_PCUPD) && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign stage_start = r_stage_start;
  assign pc_we       = r_pc_we;
  assign busy        = r_busy;
  assign stat        = r_stat;
  assign instr_count = r_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_y86_seq_sequencer.sv
// Bench for y86_seq_sequencer: random stage latencies and instructions, a
// reference model of retirement/status, and a monitor checking start pulses
// and PC updates against expectation queues.
module tb_y86_seq_sequencer;
  import y86_seq_pkg::*;

  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic [4:0]       stage_start;
  logic [4:0]       stage_done;
  logic [3:0]       icode;
  logic             instr_valid;
  logic             imem_error;
  logic             dmem_error;
  logic             pc_we;
  logic             busy;
  logic [2:0]       stat;
  logic [CNT_W-1:0] instr_count;
  logic             wdog_trip;
  logic [3:0]       dbg_state;

  y86_seq_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .stage_start (stage_start),
    .stage_done  (stage_done),
    .icode       (icode),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .dmem_error  (dmem_error),
    .pc_we       (pc_we),
    .busy        (busy),
    .stat        (stat),
    .instr_count (instr_count),
    .wdog_trip   (wdog_trip),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [4:0] exp_q[$];     // expected stage_start pulses, in order
  int         ret_q[$];     // expected instr_count at each pc_we
  int         dur_q[$];     // expected fetch-start..pc_we length
  int         fetch_cyc = 0;
  logic [2:0] m_stat;
  int         m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sample just after each rising edge, pop and compare on events.
  always @(posedge clk) begin
    #1;
    if (stage_start != '0) begin
      if (stage_start[0]) fetch_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_start", 32'(stage_start), 0);
      else chk("start_order", 32'(stage_start), 32'(exp_q.pop_front()));
    end
    if (pc_we) begin
      if (ret_q.size() == 0) begin
        chk("unexpected_pc_we", 32'(pc_we), 0);
      end else begin
        chk("retire_count", 32'(instr_count), 32'(ret_q.pop_front()));
        chk("instr_cycles", 32'(cyc - fetch_cyc + 1), 32'(dur_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    exp_q.delete();
    ret_q.delete();
    dur_q.delete();
    run        = 1'b0;
    stage_done = '0;
    reset      = 1'b1;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    m_stat  = STAT_AOK;
    m_count = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stage_start"}, 32'(stage_start), 0);
    chk({tag, "_pc_we"},       32'(pc_we), 0);
    chk({tag, "_busy"},        32'(busy), 0);
    chk({tag, "_stat"},        32'(stat), 1);
    chk({tag, "_count"},       32'(instr_count), 0);
    chk({tag, "_wdog"},        32'(wdog_trip), 0);
    chk({tag, "_state"},       32'(dbg_state), 32'(S_IDLE));
  endtask

  // Answer one stage: wait for its start pulse, then raise its done bit in
  // the (lat+1)-th cycle of the stage. Other done bits carry random noise.
  task automatic serve_stage(input int k, input int lat, output bit ok);
    logic [4:0] own;
    int n;
    own = 5'(1 << k);
    n   = 0;
    ok  = 1'b0;
    while (!stage_start[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("stage%0d_start_seen", k), 32'(stage_start[k]), 1);
    if (!stage_start[k]) return;
    for (int i = 0; i < lat; i++) begin
      stage_done = 5'($urandom) & ~own;
      @(negedge clk);
    end
    stage_done = own | (5'($urandom) & ~own);
    @(negedge clk);
    stage_done = '0;
    ok = 1'b1;
  endtask

  // One instruction: push expectations from the sequencing rules, then
  // serve the stages and update the status/count model.
  task automatic do_instr(input logic [3:0] ic, input bit valid, input bit ierr,
                          input bit derr, input int lat[5], input bit drop_run,
                          output bit ok);
    bit is_fault;
    bit is_halt;
    int dur;
    is_fault = ierr || !valid;
    is_halt  = !is_fault && (ic == I_HALT);
    exp_q.push_back(5'b00001);
    if (!is_fault && !is_halt) begin
      exp_q.push_back(5'b00010);
      exp_q.push_back(5'b00100);
      exp_q.push_back(5'b01000);
      if (!derr) begin
        exp_q.push_back(5'b10000);
        dur = 1;
        foreach (lat[k]) dur += lat[k] + 1;
        ret_q.push_back(m_count);
        dur_q.push_back(dur);
      end
    end
    icode       = ic;
    instr_valid = valid;
    imem_error  = ierr;
    dmem_error  = derr;
    serve_stage(0, lat[0], ok);
    if (!ok) return;
    if (is_fault) begin
      m_stat = ierr ? STAT_ADR : STAT_INS;
      return;
    end
    if (is_halt) begin
      m_stat = STAT_HLT;
      return;
    end
    if (drop_run) run = 1'b0;
    for (int k = 1; k < 4; k++) begin
      serve_stage(k, lat[k], ok);
      if (!ok) return;
    end
    if (derr) begin
      m_stat = STAT_ADR;
      return;
    end
    serve_stage(4, lat[4], ok);
    if (!ok) return;
    if (m_count < CNT_MAX) m_count++;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_stat"},  32'(stat), 32'(m_stat));
    chk({tag, "_count"}, 32'(instr_count), 32'(m_count));
    chk({tag, "_drained"}, 32'(exp_q.size() + ret_q.size()), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat[5];
    int zero[5];
    bit ok;
    int c0;
    int n;
    zero        = '{0, 0, 0, 0, 0};
    reset       = 1'b1;
    run         = 1'b0;
    stage_done  = '0;
    icode       = I_NOP;
    instr_valid = 1'b1;
    imem_error  = 1'b0;
    dmem_error  = 1'b0;
    m_stat      = STAT_AOK;
    m_count     = 0;

    do_reset();
    chk_reset_vals("reset");

    // Fast instructions: done in every entry cycle, 6 cycles each.
    run = 1'b1;
    for (int i = 0; i < 3; i++) do_instr(I_OPQ, 1'b1, 1'b0, 1'b0, zero, i == 2, ok);
    @(negedge clk);
    chk_model("fast");
    chk("fast_count3", 32'(instr_count), 3);
    chk("fast_idle", 32'(dbg_state), 32'(S_IDLE));
    chk("fast_busy", 32'(busy), 0);

    // Slow execute: done in the 4th execute cycle, 9-cycle instruction.
    run = 1'b1;
    lat = '{0, 0, 3, 0, 0};
    do_instr(4'($urandom_range(1, 11)), 1'b1, 1'b0, 1'b0, lat, 1'b1, ok);
    @(negedge clk);
    chk_model("slow");

    // Random back-to-back instructions; counter saturates.
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      foreach (lat[k]) lat[k] = $urandom_range(0, 3);
      do_instr(4'($urandom_range(1, 11)), 1'b1, 1'b0, 1'b0, lat, i == 19, ok);
    end
    @(negedge clk);
    chk_model("random");
    chk("saturated", 32'(instr_count), CNT_MAX);

    // Halt on the third instruction.
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      foreach (lat[k]) lat[k] = $urandom_range(0, 2);
      do_instr((i == 2) ? I_HALT : 4'($urandom_range(1, 11)), 1'b1, 1'b0, 1'b0, lat, 1'b0, ok);
    end
    repeat (10) @(negedge clk);
    chk_model("halt");
    chk("halt_stat", 32'(stat), 2);
    chk("halt_state", 32'(dbg_state), 32'(S_HALTED));
    chk("halt_busy", 32'(busy), 0);
    do_reset();
    chk_reset_vals("after_halt");

    // Fetch error priority, invalid instruction, data memory error.
    run = 1'b1;
    do_instr(I_OPQ, 1'b0, 1'b1, 1'b0, zero, 1'b0, ok);
    repeat (5) @(negedge clk);
    chk_model("imem_prio");
    chk("imem_state", 32'(dbg_state), 32'(S_FAULT));
    do_reset();
    run = 1'b1;
    do_instr(I_OPQ, 1'b0, 1'b0, 1'b0, zero, 1'b0, ok);
    repeat (5) @(negedge clk);
    chk_model("ins");
    do_reset();
    run = 1'b1;
    foreach (lat[k]) lat[k] = $urandom_range(0, 3);
    do_instr(I_MRMOVQ, 1'b1, 1'b0, 1'b1, lat, 1'b0, ok);
    repeat (5) @(negedge clk);
    chk_model("dmem");
    chk("dmem_state", 32'(dbg_state), 32'(S_FAULT));

    // Run dropped during decode: instruction completes, then IDLE.
    do_reset();
    run = 1'b1;
    foreach (lat[k]) lat[k] = $urandom_range(0, 3);
    do_instr(I_IRMOVQ, 1'b1, 1'b0, 1'b0, lat, 1'b1, ok);
    repeat (10) @(negedge clk);
    chk_model("run_drop");
    chk("run_drop_idle", 32'(dbg_state), 32'(S_IDLE));

    // Reset while in execute after one retired instruction.
    do_reset();
    run = 1'b1;
    do_instr(I_OPQ, 1'b1, 1'b0, 1'b0, zero, 1'b0, ok);
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00010);
    exp_q.push_back(5'b00100);
    serve_stage(0, 0, ok);
    serve_stage(1, 0, ok);
    chk("exec_entered", 32'(dbg_state), 32'(S_EXEC));
    chk("exec_count", 32'(instr_count), 1);
    run   = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    ret_q.delete();
    dur_q.delete();
    @(negedge clk);
    chk_reset_vals("reset_in_exec");
    reset   = 1'b0;
    m_stat  = STAT_AOK;
    m_count = 0;

    // Decode done never arrives.
    do_reset();
    run = 1'b1;
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00010);
    icode       = I_OPQ;
    instr_valid = 1'b1;
    serve_stage(0, 0, ok);
    chk("decode_start", 32'(stage_start), 32'(5'b00010));
    c0 = cyc;
    stage_done = 5'b11101;
`ifdef Y86_SEQ_WDOG_EN
    n = 0;
    while (dbg_state != 4'(S_FAULT) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wdog_fault_reached", 32'(dbg_state), 32'(S_FAULT));
    chk("wdog_latency", 32'(cyc - c0), TIMEOUT);
    chk("wdog_trip", 32'(wdog_trip), 1);
    chk("wdog_stat", 32'(stat), 32'(STAT_ADR));
    chk("wdog_count", 32'(instr_count), 0);
`else
    n = 0;
    repeat (100) @(negedge clk);
    chk("nowdog_state", 32'(dbg_state), 32'(S_DECODE));
    chk("nowdog_cycles", 32'(cyc - c0 >= 100), 1);
    chk("nowdog_stat", 32'(stat), 32'(STAT_AOK));
    chk("nowdog_trip", 32'(wdog_trip), 0);
    chk("nowdog_busy", 32'(busy), 1);
`endif
    stage_done = '0;
    chk("final_drained", 32'(exp_q.size() + ret_q.size() + n * 0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
